cc_reorder_merge_unit: RTL and testbench
========================================

// Module: cc_reorder_merge_unit
// PURPOSE
//  Read-return merge stage of the cache controller: replays cache-line reads to INCT in request order.
//  The per-request flag FIFO holds {hit, start_beat}. Hit lines are serialized from the hit-data FIFO,
//  critical beat first and wrapping. Misses stream from the MEM AXI R channel.
//  Output goes through a one-entry register slice. Sticky error flags cover overflow and bad bursts.
// PARAMETERS
//  DATA_W       64  R-channel beat width (bits)
//  BEATS        8   beats per cache line (power of 2, >=2); line = DATA_W*BEATS bits
//  FLAG_DEPTH   16  flag FIFO entries (power of 2)
//  HDATA_DEPTH  16  hit-data FIFO entries (power of 2)
//  AFULL_MARGIN 1   afull asserted when count >= DEPTH-AFULL_MARGIN
//  (local) OFS_W = $clog2(BEATS)
// PORTS
//  clk               in   1              clock
//  rst               in   1              reset, asynchronous, active-high
//  mem_rdata_i       in   DATA_W         MEM R data
//  mem_rlast_i       in   1              MEM R last
//  mem_rvalid_i      in   1              MEM R valid
//  mem_rready_o      out  1              MEM R ready
//  flag_wren_i       in   1              push request descriptor
//  flag_wdata_i      in   1+OFS_W        {hit, start_beat}
//  flag_afull_o      out  1              flag FIFO almost full
//  hdata_wren_i      in   1              push hit line
//  hdata_wdata_i     in   DATA_W*BEATS   hit line, beat k = bits [k*DATA_W +: DATA_W]
//  hdata_afull_o     out  1              hit-data FIFO almost full
//  inct_rdata_o      out  DATA_W         INCT R data (registered)
//  inct_rlast_o      out  1              INCT R last (registered)
//  inct_rvalid_o     out  1              INCT R valid (registered)
//  inct_rready_i     in   1              INCT R ready
//  err_o             out  2              sticky: [0] FIFO overflow push, [1] MEM rlast mismatch
// BEHAVIOUR
//  Reset: both FIFOs empty, FSM=IDLE, beat_cnt=0, all outputs 0 (rvalid, rlast, rdata, rready, afull, err).
//   Reset asserted mid-burst aborts the burst. Partial beats are discarded.
//  FIFOs: synchronous, show-ahead. Simultaneous push+pop at full is legal and count is unchanged.
//   A push while full (and no pop) is dropped and sets err_o[0].
//  Out slice: "free" = !inct_rvalid_o | inct_rready_i. It loads a new beat only when free.
//   It holds rdata/rlast stable while rvalid=1 and ready=0. Latency is source beat to inct_rvalid_o = 1 cycle.
//  FSM:
//   IDLE: flag FIFO non-empty -> HIT if head.hit=1, else MISS.
//    beat_cnt<=0. ofs<=head.start_beat. No beat is issued in IDLE.
//   HIT: issue when hdata FIFO non-empty & free. Data = line beat ((ofs+beat_cnt) mod BEATS), natural OFS_W wrap.
//    rlast=(beat_cnt==BEATS-1). If hdata is empty, stall with no bubble data issued.
//    On the last beat: pop hdata and flag, ->IDLE, or directly to the next HIT/MISS if the flag FIFO is still
//    non-empty after the pop. This gives back-to-back bursts with no idle cycle.
//   MISS: mem_rready_o = free. A beat is accepted on mem_rvalid_i & mem_rready_o.
//    Data passes through, start_beat is ignored (MEM already wraps). rlast=(beat_cnt==BEATS-1), from the counter.
//    If mem_rlast_i != (beat_cnt==BEATS-1) on an accepted beat, set err_o[1] and keep counting.
//    On the last beat: pop flag, then next state as in HIT.
//   mem_rready_o=0 outside MISS.
//  beat_cnt: OFS_W bits. Increments per issued beat and wraps to 0 after BEATS-1.
//  Flag push and pop in the same cycle are both honoured. A flag pushed into an empty FIFO is visible the next cycle.
//  afull: combinational from registered counts.
//  err_o: cleared only by rst.
// TESTING
//  1 Hit, start=0: push flag{1,0} and line beats 0..7 = 0xA0..0xA7, ready=1
//    -> 8 beats 0xA0..0xA7 on consecutive cycles, rlast on 0xA7.
//  2 Critical-first: flag{1,5}, same line -> order A5,A6,A7,A0..A4, rlast on A4. Both FIFOs empty afterwards.
//  3 Order: flags miss,hit,miss. MEM returns bursts M0..M7, then N0..N7. Hit line is H.
//    -> INCT sees M*, then H*, then N*. mem_rready_o=0 during the H burst.
//  4 Backpressure: inct_rready_i toggles 1010.. mid-burst -> no beat lost or duplicated.
//    Data is stable while stalled. Total 8 beats.
//  5 Boundaries: push 16 flags with no pop -> afull at count 15. The 17th push sets err_o[0].
//    A MEM burst with rlast on beat 3 sets err_o[1] and inct_rlast still appears on beat 7.
//  6 Reset mid-burst: rst=1 after beat 3 of a hit -> all outputs 0 next edge. The post-reset hit replays from beat 0.

Source files
------------

// File: rtl/cc_reorder_merge_unit.sv
// Read-return merge: replays hit lines (critical beat first) and MEM miss bursts to INCT in request order.
// Latency: source beat to inct_rvalid_o is 1 cycle. Backpressure: the out slice loads only when free; MEM sees ready=free.

// Show-ahead FIFO with a peek port (head when peek_next_i=0, head+1 otherwise).
// Latency: a push is visible the next cycle. Backpressure: a push while full without a pop is dropped and flagged.
module cc_rmu_fifo #(
  parameter int W            = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  input  logic         peek_next_i,
  output logic [W-1:0] rdata_o,
  output logic         avail_o,
  output logic         afull_o,
  output logic         ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full, do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;
  assign afull_o = (cnt_q >= (AW+1)'(DEPTH - AFULL_MARGIN));
  assign avail_o = peek_next_i ? (cnt_q > (AW+1)'(1)) : (cnt_q != '0);
  assign rdata_o = mem_q[rd_ptr_q + AW'(peek_next_i)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module cc_reorder_merge_unit #(
  parameter int DATA_W       = 64,
  parameter int BEATS        = 8,
  parameter int FLAG_DEPTH   = 16,
  parameter int HDATA_DEPTH  = 16,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_rready_o,
  input  logic                    flag_wren_i,
  input  logic [$clog2(BEATS):0]  flag_wdata_i,
  output logic                    flag_afull_o,
  input  logic                    hdata_wren_i,
  input  logic [DATA_W*BEATS-1:0] hdata_wdata_i,
  output logic                    hdata_afull_o,
  output logic [DATA_W-1:0]       inct_rdata_o,
  output logic                    inct_rlast_o,
  output logic                    inct_rvalid_o,
  input  logic                    inct_rready_i,
  output logic [1:0]              err_o
);
  localparam int OFS_W = $clog2(BEATS);
  localparam int FW    = 1 + OFS_W;
  localparam int LW    = DATA_W * BEATS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIT  = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [OFS_W-1:0]  beat_cnt_q, beat_cnt_d, ofs_q, ofs_d, idx;
  logic [1:0]        err_q, err_d;
  logic              out_vld_q, out_last_q;
  logic [DATA_W-1:0] out_dat_q, beat_dat;
  logic              free, issue, is_last, flag_pop, hd_pop;
  logic [FW-1:0]     flag_rdata;
  logic [LW-1:0]     hd_rdata;
  logic              flag_avail, hd_avail, flag_ovf, hd_ovf;

  // Outside IDLE the flag FIFO is peeked one entry ahead so a burst can chain without an idle cycle.
  cc_rmu_fifo #(.W(FW), .DEPTH(FLAG_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) u_flag_fifo (
    .clk(clk), .rst(rst), .push_i(flag_wren_i), .wdata_i(flag_wdata_i), .pop_i(flag_pop),
    .peek_next_i(state_q != ST_IDLE), .rdata_o(flag_rdata), .avail_o(flag_avail),
    .afull_o(flag_afull_o), .ovf_o(flag_ovf)
  );

  cc_rmu_fifo #(.W(LW), .DEPTH(HDATA_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) u_hdata_fifo (
    .clk(clk), .rst(rst), .push_i(hdata_wren_i), .wdata_i(hdata_wdata_i), .pop_i(hd_pop),
    .peek_next_i(1'b0), .rdata_o(hd_rdata), .avail_o(hd_avail),
    .afull_o(hdata_afull_o), .ovf_o(hd_ovf)
  );

  assign free    = !out_vld_q || inct_rready_i;
  assign idx     = ofs_q + beat_cnt_q;
  assign is_last = (beat_cnt_q == OFS_W'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    ofs_d        = ofs_q;
    err_d        = err_q;
    issue        = 1'b0;
    beat_dat     = '0;
    flag_pop     = 1'b0;
    hd_pop       = 1'b0;
    mem_rready_o = 1'b0;
    if (flag_ovf || hd_ovf) err_d[0] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (flag_avail) begin
          state_d    = flag_rdata[OFS_W] ? ST_HIT : ST_MISS;
          beat_cnt_d = '0;
          ofs_d      = flag_rdata[OFS_W-1:0];
        end
      end
      ST_HIT: begin
        if (hd_avail && free) begin
          issue    = 1'b1;
          beat_dat = hd_rdata[idx*DATA_W +: DATA_W];
        end
      end
      ST_MISS: begin
        mem_rready_o = free;
        if (mem_rvalid_i && free) begin
          issue    = 1'b1;
          beat_dat = mem_rdata_i;
          if (mem_rlast_i != is_last) err_d[1] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      beat_cnt_d = beat_cnt_q + OFS_W'(1);
      if (is_last) begin
        flag_pop = 1'b1;
        hd_pop   = (state_q == ST_HIT);
        if (flag_avail) begin
          state_d = flag_rdata[OFS_W] ? ST_HIT : ST_MISS;
          ofs_d   = flag_rdata[OFS_W-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      ofs_q      <= '0;
      err_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      ofs_q      <= ofs_d;
      err_q      <= err_d;
      if (issue) begin
        out_vld_q  <= 1'b1;
        out_dat_q  <= beat_dat;
        out_last_q <= is_last;
      end else if (inct_rready_i) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign inct_rvalid_o = out_vld_q;
  assign inct_rdata_o  = out_dat_q;
  assign inct_rlast_o  = out_last_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_cc_reorder_merge_unit.sv
// Directed scoreboard bench for cc_reorder_merge_unit: expected beats are queued at stimulus time and
// compared in order as INCT handshakes occur; MEM bursts are served from a source queue.
module tb_cc_reorder_merge_unit;
  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  mem_rdata_i;
  logic         mem_rlast_i, mem_rvalid_i, mem_rready_o;
  logic         flag_wren_i;
  logic [3:0]   flag_wdata_i;
  logic         flag_afull_o;
  logic         hdata_wren_i;
  logic [511:0] hdata_wdata_i;
  logic         hdata_afull_o;
  logic [63:0]  inct_rdata_o;
  logic         inct_rlast_o, inct_rvalid_o, inct_rready_i;
  logic [1:0]   err_o;

  typedef struct {
    logic [63:0] dat;
    logic        last;
    bit          mem_lo;
    bit          consec;
  } exp_t;

  typedef struct {
    logic [63:0] dat;
    logic        last;
  } mem_t;

  exp_t        sb[$];
  mem_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  int          last_hs = 0;
  logic        stall_q = 1'b0;
  logic [63:0] stall_dat = '0;

  cc_reorder_merge_unit dut (
    .clk(clk), .rst(rst),
    .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rready_o(mem_rready_o),
    .flag_wren_i(flag_wren_i), .flag_wdata_i(flag_wdata_i), .flag_afull_o(flag_afull_o),
    .hdata_wren_i(hdata_wren_i), .hdata_wdata_i(hdata_wdata_i), .hdata_afull_o(hdata_afull_o),
    .inct_rdata_o(inct_rdata_o), .inct_rlast_o(inct_rlast_o), .inct_rvalid_o(inct_rvalid_o),
    .inct_rready_i(inct_rready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: compare at the negedge, advance the MEM source after the posedge.
  task automatic cyc();
    exp_t e;
    logic mem_acc;
    @(negedge clk);
    cyc_no++;
    if (stall_q) begin
      chk("stall_vld", inct_rvalid_o, 1'b1);
      chk("stall_dat", inct_rdata_o, stall_dat);
    end
    if (inct_rvalid_o && inct_rready_i) begin
      if (sb.size() == 0) begin
        chk("extra_beat", inct_rvalid_o, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("rdata", inct_rdata_o, e.dat);
        chk("rlast", inct_rlast_o, e.last);
        if (e.mem_lo) chk("mem_rready_in_hit", mem_rready_o, 1'b0);
        if (e.consec) chk("consecutive", cyc_no, last_hs + 1);
      end
      last_hs = cyc_no;
    end
    stall_q   = inct_rvalid_o && !inct_rready_i;
    stall_dat = inct_rdata_o;
    mem_acc   = mem_rvalid_i && mem_rready_o;
    @(posedge clk);
    #1;
    if (mem_acc) void'(mq.pop_front());
    mem_rvalid_i = (mq.size() != 0);
    mem_rdata_i  = (mq.size() != 0) ? mq[0].dat : '0;
    mem_rlast_i  = (mq.size() != 0) ? mq[0].last : 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic push_flag(input logic hit, input logic [2:0] st);
    flag_wren_i  = 1'b1;
    flag_wdata_i = {hit, st};
    cyc();
    flag_wren_i  = 1'b0;
  endtask

  task automatic push_hit(input logic [63:0] base, input logic [2:0] st);
    for (int k = 0; k < 8; k++) hdata_wdata_i[k*64 +: 64] = base + 64'(k);
    hdata_wren_i = 1'b1;
    push_flag(1'b1, st);
    hdata_wren_i = 1'b0;
  endtask

  task automatic exp_hit(input logic [63:0] base, input int st, input bit consec);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      e.dat    = base + 64'((st + j) % 8);
      e.last   = (j == 7);
      e.mem_lo = (j != 7);
      e.consec = consec && (j != 0);
      sb.push_back(e);
    end
  endtask

  task automatic exp_miss(input logic [63:0] base);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      e.dat    = base + 64'(j);
      e.last   = (j == 7);
      e.mem_lo = 1'b0;
      e.consec = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic mem_burst(input logic [63:0] base, input int lastpos);
    mem_t m;
    for (int j = 0; j < 8; j++) begin
      m.dat  = base + 64'(j);
      m.last = (j == lastpos);
      mq.push_back(m);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rvalid"}, inct_rvalid_o, 1'b0);
    chk({tag, "_rlast"}, inct_rlast_o, 1'b0);
    chk({tag, "_rdata"}, inct_rdata_o, 64'h0);
    chk({tag, "_mem_rready"}, mem_rready_o, 1'b0);
    chk({tag, "_flag_afull"}, flag_afull_o, 1'b0);
    chk({tag, "_hdata_afull"}, hdata_afull_o, 1'b0);
    chk({tag, "_err"}, err_o, 2'b00);
  endtask

  initial begin
    rst           = 1'b1;
    mem_rdata_i   = '0;
    mem_rlast_i   = 1'b0;
    mem_rvalid_i  = 1'b0;
    flag_wren_i   = 1'b0;
    flag_wdata_i  = '0;
    hdata_wren_i  = 1'b0;
    hdata_wdata_i = '0;
    inct_rready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Hit line, start beat 0, consecutive beats
    exp_hit(64'hA0, 0, 1'b1);
    push_hit(64'hA0, 3'd0);
    drain("t1_drain", 40);

    // Critical beat first with wrap
    exp_hit(64'hA0, 5, 1'b1);
    push_hit(64'hA0, 3'd5);
    drain("t2_drain", 40);
    chk("t2_flag_afull", flag_afull_o, 1'b0);
    chk("t2_hdata_afull", hdata_afull_o, 1'b0);

    // Ordering miss, hit, miss with MEM data waiting throughout
    exp_miss(64'h100);
    exp_hit(64'h300, 0, 1'b0);
    exp_miss(64'h200);
    mem_burst(64'h100, 7);
    mem_burst(64'h200, 7);
    push_flag(1'b0, 3'd0);
    push_hit(64'h300, 3'd0);
    push_flag(1'b0, 3'd0);
    drain("t3_drain", 100);
    chk("t3_mem_consumed", mq.size(), 0);

    // Backpressure toggling mid-burst
    exp_hit(64'hB0, 3, 1'b0);
    push_hit(64'hB0, 3'd3);
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      inct_rready_i = (i % 2 == 0);
      cyc();
    end
    inct_rready_i = 1'b1;
    chk("t4_drain", sb.size(), 0);
    repeat (3) cyc();

    // Flag FIFO fill, afull threshold, overflow
    for (int i = 1; i <= 16; i++) begin
      push_flag(1'b0, 3'd0);
      if (i == 14) chk("t5_afull_at14", flag_afull_o, 1'b0);
      if (i == 15) chk("t5_afull_at15", flag_afull_o, 1'b1);
    end
    chk("t5_err_before_ovf", err_o, 2'b00);
    push_flag(1'b0, 3'd0);
    chk("t5_err_ovf", err_o, 2'b01);
    // First burst carries rlast early on beat 3
    for (int i = 0; i < 16; i++) begin
      exp_miss(64'h400 + 64'(i * 16));
      mem_burst(64'h400 + 64'(i * 16), (i == 0) ? 3 : 7);
    end
    drain("t5_drain", 400);
    chk("t5_err_both", err_o, 2'b11);
    chk("t5_afull_after", flag_afull_o, 1'b0);
    chk("t5_mem_consumed", mq.size(), 0);
    repeat (2) cyc();

    // Reset in the middle of a hit burst
    exp_hit(64'hD0, 0, 1'b0);
    push_hit(64'hD0, 3'd0);
    for (int i = 0; i < 40 && sb.size() > 4; i++) cyc();
    chk("t6_setup", sb.size(), 4);
    rst = 1'b1;
    #1;
    chk_outputs_zero("t6_reset");
    sb.delete();
    stall_q = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_hit(64'hD0, 0, 1'b0);
    push_hit(64'hD0, 3'd0);
    drain("t6_drain", 40);
    chk("t6_err_after", err_o, 2'b00);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
